// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of a single-port data RAM
// (combinational read, synchronous write). Round-robin grant per cycle,
// bounded bus lock for read-modify-write sequences and a one-cycle
// registered read response per master.
// Optional build macro DMEM_ARB_STATS_EN adds a saturating conflict counter.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  // Count value at which the next locked grant exhausts the lock budget.
  localparam logic [CW-1:0] LAST_CNT = CW'(LOCK_MAX - 1);
  // With a budget of one cycle a lock never outlives its first grant.
  localparam bit LOCK_EN = (LOCK_MAX > 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state;
  logic            last;      // 1: m1 won most recently, so m0 is favoured
  logic [CW-1:0]   lock_cnt;
  logic            gnt0;
  logic            gnt1;
  logic [DW-1:0]   rdata0_p1;
  logic [DW-1:0]   rdata1_p1;
  logic            vld0_p1;
  logic            vld1_p1;

  // Grant decision: round-robin in IDLE, exclusive to the owner while locked.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          gnt0 = m0_req && (!m1_req || last);
          gnt1 = m1_req && (!m0_req || !last);
        end
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  // RAM port mux driven by whichever master holds the grant.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (gnt0) begin
      mem_addr = m0_addr;
      mem_din  = m0_wdata;
      mem_we   = m0_we;
    end else if (gnt1) begin
      mem_addr = m1_addr;
      mem_din  = m1_wdata;
      mem_we   = m1_we;
    end
  end

  // Ownership FSM: round-robin history, lock entry/exit and lock budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            last <= 1'b0;
            if (m0_lock && LOCK_EN) begin
              state    <= OWN0;
              lock_cnt <= CW'(1);
            end
          end else if (gnt1) begin
            last <= 1'b1;
            if (m1_lock && LOCK_EN) begin
              state    <= OWN1;
              lock_cnt <= CW'(1);
            end
          end
        end
        OWN0: begin
          if (!m0_req) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (!m0_lock || lock_cnt >= LAST_CNT) begin
            // Released voluntarily or budget spent; m1 goes next if waiting.
            state    <= IDLE;
            lock_cnt <= '0;
            last     <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        OWN1: begin
          if (!m1_req) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (!m1_lock || lock_cnt >= LAST_CNT) begin
            state    <= IDLE;
            lock_cnt <= '0;
            last     <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  // Read response stage: capture RAM data on a granted read, pulse valid once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_p1 <= '0;
      rdata1_p1 <= '0;
      vld0_p1   <= 1'b0;
      vld1_p1   <= 1'b0;
    end else begin
      vld0_p1 <= gnt0 && !m0_we;
      vld1_p1 <= gnt1 && !m1_we;
      if (gnt0 && !m0_we) rdata0_p1 <= mem_dout;
      if (gnt1 && !m1_we) rdata1_p1 <= mem_dout;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rdata  = rdata0_p1;
  assign m1_rdata  = rdata1_p1;
  assign m0_rvalid = vld0_p1;
  assign m1_rvalid = vld1_p1;

`ifdef DMEM_ARB_STATS_EN
  // Saturating count of cycles where both masters asked and one was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (m0_req && m1_req && (!gnt0 || !gnt1) && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// RAM and per-master read-response scoreboards.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic [DW-1:0] m0_rdata;
  logic          m0_rvalid;
  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic [DW-1:0] m1_rdata;
  logic          m1_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  logic e0, e1;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Behavioural RAM: preloaded with pat(addr) on the first clock (under reset).
  logic [7:0] ram [256];
  logic       ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(8'(i));
      ram_init <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response monitor: rvalid must pulse exactly on the cycle a response is due.
  always @(negedge clk) begin
    e0 = (q0.size() > 0) && (q0[0].due == cyc);
    e1 = (q1.size() > 0) && (q1[0].due == cyc);
    chk("m0_rvalid", m0_rvalid, e0);
    chk("m1_rvalid", m1_rvalid, e1);
    if (e0) begin
      chk("m0_rdata", m0_rdata, q0[0].data);
      void'(q0.pop_front());
    end
    if (e1) begin
      chk("m1_rdata", m1_rdata, q1[0].data);
      void'(q1.pop_front());
    end
  end

  task automatic set0(input logic r, input logic w, input logic l, input logic [7:0] a, input logic [7:0] d);
    m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input logic [7:0] a, input logic [7:0] d);
    m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
  endtask

  task automatic push0(input logic [7:0] d);
    rsp_t r;
    r.data = d;
    r.due  = cyc + 1;
    q0.push_back(r);
  endtask

  task automatic push1(input logic [7:0] d);
    rsp_t r;
    r.data = d;
    r.due  = cyc + 1;
    q1.push_back(r);
  endtask

  task automatic step(input string tag, input logic eg0, input logic eg1, input logic ewe,
                      input logic [7:0] ea, input logic [7:0] ed);
    @(negedge clk);
    chk({tag, ".g0"}, m0_gnt, eg0);
    chk({tag, ".g1"}, m1_gnt, eg1);
    chk({tag, ".we"}, mem_we, ewe);
    chk({tag, ".addr"}, mem_addr, ea);
    chk({tag, ".din"}, mem_din, ed);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set0(1, 1, 0, 8'h05, 8'h99);
    set1(1, 0, 0, 8'h06, 8'h00);

    // Reset state: requests present but nothing may be granted or written.
    @(negedge clk);
    chk("rst.g0", m0_gnt, 0);
    chk("rst.g1", m1_gnt, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.m0_rdata", m0_rdata, 0);
    chk("rst.m1_rdata", m1_rdata, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst.conflict", conflict_cnt, 0);
`endif
    do_reset();

    // Write then read back the same address from m0.
    set0(1, 1, 0, 8'h10, 8'hA5);
    step("t1_wr", 1, 0, 1, 8'h10, 8'hA5);
    set0(1, 0, 0, 8'h10, 8'h00);
    push0(8'hA5);
    step("t1_rd", 1, 0, 0, 8'h10, 8'h00);
    set0(0, 0, 0, 8'h00, 8'h00);
    step("t1_idle", 0, 0, 0, 8'h00, 8'h00);

    // Both masters reading continuously: strict alternation starting at m0.
    do_reset();
    set0(1, 0, 0, 8'h20, 8'h00);
    set1(1, 0, 0, 8'h30, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        push0(pat(8'h20));
        step("t2_rr0", 1, 0, 0, 8'h20, 8'h00);
      end else begin
        push1(pat(8'h30));
        step("t2_rr1", 0, 1, 0, 8'h30, 8'h00);
      end
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step("t2_idle", 0, 0, 0, 8'h00, 8'h00);

    // m1 lock held against a competing m0: four m1 grants, then m0, then m1.
    set1(1, 0, 1, 8'h40, 8'h00);
    push1(pat(8'h40));
    step("t3_c1", 0, 1, 0, 8'h40, 8'h00);
    set0(1, 0, 0, 8'h50, 8'h00);
    for (int i = 0; i < 3; i++) begin
      push1(pat(8'h40));
      step("t3_lk", 0, 1, 0, 8'h40, 8'h00);
    end
    push0(pat(8'h50));
    step("t3_c5", 1, 0, 0, 8'h50, 8'h00);
    push1(pat(8'h40));
    step("t3_c6", 0, 1, 0, 8'h40, 8'h00);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step("t3_idle", 0, 0, 0, 8'h00, 8'h00);

    // m0 takes lock with a write, then drops req: one dead cycle, then m1.
    set0(1, 1, 1, 8'h60, 8'h77);
    set1(1, 0, 0, 8'h60, 8'h00);
    step("t4_lock", 1, 0, 1, 8'h60, 8'h77);
    set0(0, 0, 0, 8'h00, 8'h00);
    step("t4_drop", 0, 0, 0, 8'h00, 8'h00);
    push1(8'h77);
    step("t4_m1", 0, 1, 0, 8'h60, 8'h00);
    set0(1, 0, 0, 8'h60, 8'h00);
    push0(8'h77);
    step("t4_rr", 1, 0, 0, 8'h60, 8'h00);
    set0(0, 0, 0, 0, 0);
    set1(1, 1, 0, 8'h61, 8'h3C);
    step("t4_m1wr", 0, 1, 1, 8'h61, 8'h3C);
    set1(1, 0, 0, 8'h61, 8'h00);
    push1(8'h3C);
    step("t4_m1rd", 0, 1, 0, 8'h61, 8'h00);
    set1(0, 0, 0, 0, 0);
    step("t4_idle", 0, 0, 0, 8'h00, 8'h00);

    // Reset right after a granted m1 read: the response must be dropped.
    set1(1, 0, 0, 8'h70, 8'h00);
    step("t5_rd", 0, 1, 0, 8'h70, 8'h00);
    rst_n = 1'b0;
    set0(1, 1, 0, 8'h71, 8'h11);
    @(negedge clk);
    chk("t5.g0", m0_gnt, 0);
    chk("t5.g1", m1_gnt, 0);
    chk("t5.we", mem_we, 0);
    chk("t5.m1_rdata", m1_rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set0(1, 0, 0, 8'h72, 8'h00);
    set1(1, 0, 0, 8'h73, 8'h00);
    push0(pat(8'h72));
    step("t5_post", 1, 0, 0, 8'h72, 8'h00);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step("t5_idle", 0, 0, 0, 8'h00, 8'h00);

`ifdef DMEM_ARB_STATS_EN
    // Contended write cycles feed the conflict counter until it saturates.
    do_reset();
    set0(1, 1, 0, 8'h80, 8'h01);
    set1(1, 1, 0, 8'h81, 8'h02);
    repeat (10) @(posedge clk);
    #1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    chk("st.cnt10", conflict_cnt, 16'd10);
    set0(1, 1, 0, 8'h80, 8'h01);
    set1(1, 1, 0, 8'h81, 8'h02);
    repeat (16'hFFFE - 10) @(posedge clk);
    #1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    chk("st.cntFFFE", conflict_cnt, 16'hFFFE);
    set0(1, 1, 0, 8'h80, 8'h01);
    set1(1, 1, 0, 8'h81, 8'h02);
    repeat (3) @(posedge clk);
    #1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    chk("st.sat", conflict_cnt, 16'hFFFF);
`endif

    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
